dcm_reset_sequencer: RTL and testbench



---
 rtl/dcm_seq_pkg.sv | 28 ++
 rtl/dcm_seq_sync.sv | 26 ++
 rtl/dcm_reset_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dcm_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_seq_pkg.sv
// Shared encodings and constants for the DCM reset sequencer.
package dcm_seq_pkg;

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_PULSE     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  typedef enum logic [2:0] {
    S_RESET     = ST_RESET,
    S_PULSE     = ST_PULSE,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_SETTLE    = ST_SETTLE,
    S_RUN       = ST_RUN,
    S_FAIL      = ST_FAIL
  } seq_state_e;

  localparam int DCM_STATUS_CLKFX_STOPPED_BIT = 2;
  localparam int LOCK_LOSS_MAX                = 255;

  // States in which the DCM is held in reset.
  function automatic logic holds_dcm_rst(input seq_state_e s);
    return (s == S_RESET) || (s == S_PULSE) || (s == S_FAIL);
  endfunction

endpackage

// File: rtl/dcm_seq_sync.sv
// Two-flop synchroniser, async active-low clear to 0.
module dcm_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// DCM reset / lock supervisor with bounded retries and settle-gated core reset release.
// Optional CLKFX-stopped monitoring is enabled by defining DCM_CLKFX_WATCH_EN.
//
// state     | meaning
// RESET     | board reset just released, one cycle
// PULSE     | dcm_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK | dcm_rst low, waiting for LOCKED or timeout
// SETTLE    | lock must stay good for SETTLE_CYCLES
// RUN       | core reset released
// FAIL      | retries exhausted, waiting for restart_req
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_WIDTH           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dcm_locked,
  input  logic [7:0] dcm_status,
  input  logic       restart_req,
  output logic       dcm_rst,
  output logic       core_rst,
  output logic [2:0] seq_state,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic       fail
);

  localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMER_MAX    = '1;
  localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);
  localparam logic [7:0]           LOSS_LIMIT   = 8'(LOCK_LOSS_MAX);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic [2:0]           retry_q, retry_d;
  logic [7:0]           lock_loss_q, lock_loss_d;
  logic                 dcm_rst_q, core_rst_q, fail_q;

  logic                 locked_s;
  logic                 lock_bad;
  logic [3:0]           retry_inc;

  dcm_seq_sync #(.WIDTH(1)) u_sync_locked (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dcm_locked),
    .q_o     (locked_s)
  );

`ifdef DCM_CLKFX_WATCH_EN
  logic clkfx_stopped_s;
  logic unused_status;

  dcm_seq_sync #(.WIDTH(1)) u_sync_clkfx (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dcm_status[DCM_STATUS_CLKFX_STOPPED_BIT]),
    .q_o     (clkfx_stopped_s)
  );

  assign unused_status = ^{dcm_status[7:3], dcm_status[1:0]};
  // A stopped CLKFX output is as fatal as a lost lock once we are past WAIT_LOCK.
  assign lock_bad = !locked_s || clkfx_stopped_s;
`else
  logic unused_status;

  assign unused_status = ^dcm_status;
  assign lock_bad      = !locked_s;
`endif

  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
  assign retry_inc = {1'b0, retry_q} + 4'd1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_inc;
    retry_d     = retry_q;
    lock_loss_d = lock_loss_q;

    if (restart_req && (state_q != S_PULSE)) begin
      state_d = S_PULSE;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_d = S_PULSE;
          timer_d = '0;
        end
        S_PULSE: begin
          if (timer_q == PULSE_LAST) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (locked_s) begin
            state_d = S_SETTLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_d = '0;
            retry_d = retry_inc[3] ? 3'd7 : retry_inc[2:0];
            state_d = (retry_inc > RETRY_LIMIT) ? S_FAIL : S_PULSE;
          end
        end
        S_SETTLE: begin
          if (lock_bad) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == SETTLE_LAST) begin
            state_d = S_RUN;
            timer_d = '0;
          end
        end
        S_RUN: begin
          timer_d = '0;
          if (lock_bad) begin
            state_d     = S_PULSE;
            retry_d     = '0;
            lock_loss_d = (lock_loss_q == LOSS_LIMIT) ? lock_loss_q : lock_loss_q + 8'd1;
          end
        end
        S_FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = S_RESET;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_loss_q <= '0;
      dcm_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_loss_q <= lock_loss_d;
      dcm_rst_q   <= holds_dcm_rst(state_d);
      core_rst_q  <= (state_d != S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign dcm_rst         = dcm_rst_q;
  assign core_rst        = core_rst_q;
  assign seq_state       = state_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = lock_loss_q;
  assign fail            = fail_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Directed bench for dcm_reset_sequencer with short timing parameters.
module tb_dcm_reset_sequencer;

  localparam logic [2:0] T_RESET = 3'd0;
  localparam logic [2:0] T_PULSE = 3'd1;
  localparam logic [2:0] T_WAIT  = 3'd2;
  localparam logic [2:0] T_SETTL = 3'd3;
  localparam logic [2:0] T_RUN   = 3'd4;
  localparam logic [2:0] T_FAIL  = 3'd5;

  logic       clk, reset_n, dcm_locked, restart_req;
  logic [7:0] dcm_status;
  logic       dcm_rst, core_rst, fail;
  logic [2:0] seq_state, retry_count;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_fail   = 0;

  dcm_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (100),
    .SETTLE_CYCLES       (16),
    .MAX_RETRIES         (2),
    .CNT_WIDTH           (20)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dcm_locked      (dcm_locked),
    .dcm_status      (dcm_status),
    .restart_req     (restart_req),
    .dcm_rst         (dcm_rst),
    .core_rst        (core_rst),
    .seq_state       (seq_state),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .fail            (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st);
    chk(tag, 32'(seq_state), 32'(st));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int i;
    i = 0;
    while ((seq_state !== st) && (i < budget)) begin
      tick(1);
      i++;
    end
    chk_state(tag, st);
  endtask

  initial begin
    reset_n     = 1'b1;
    dcm_locked  = 1'b0;
    dcm_status  = 8'h00;
    restart_req = 1'b0;
    #2 reset_n = 1'b0;
    tick(3);

    chk_state("rst_state", T_RESET);
    chk("rst_dcm_rst", 32'(dcm_rst), 32'd1);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_retry", 32'(retry_count), 32'd0);
    chk("rst_loss", 32'(lock_loss_count), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);

    // Nominal bring-up
    reset_n = 1'b1;
    tick(1);
    chk_state("nom_pulse_enter", T_PULSE);
    chk("nom_dcm_rst_hi", 32'(dcm_rst), 32'd1);
    tick(3);
    chk_state("nom_pulse_last", T_PULSE);
    chk("nom_dcm_rst_last", 32'(dcm_rst), 32'd1);
    tick(1);
    chk_state("nom_wait", T_WAIT);
    chk("nom_dcm_rst_lo", 32'(dcm_rst), 32'd0);
    tick(20);
    dcm_locked = 1'b1;
    tick(2);
    chk_state("nom_sync_latency", T_WAIT);
    tick(1);
    chk_state("nom_settle", T_SETTL);
    tick(15);
    chk_state("nom_settle_last", T_SETTL);
    chk("nom_core_rst_held", 32'(core_rst), 32'd1);
    tick(1);
    chk_state("nom_run", T_RUN);
    chk("nom_core_rst_rel", 32'(core_rst), 32'd0);
    chk("nom_retry", 32'(retry_count), 32'd0);
    chk("nom_dcm_rst_run", 32'(dcm_rst), 32'd0);

    // Lock loss in RUN
    dcm_locked = 1'b0;
    tick(2);
    chk_state("loss_still_run", T_RUN);
    chk("loss_core_rst_lat", 32'(core_rst), 32'd0);
    tick(1);
    chk_state("loss_pulse", T_PULSE);
    chk("loss_core_rst", 32'(core_rst), 32'd1);
    chk("loss_dcm_rst", 32'(dcm_rst), 32'd1);
    chk("loss_count1", 32'(lock_loss_count), 32'd1);
    tick(3);
    chk("loss_pulse_last", 32'(dcm_rst), 32'd1);
    tick(1);
    chk("loss_pulse_end", 32'(dcm_rst), 32'd0);
    chk_state("loss_wait", T_WAIT);

    for (int k = 0; k < 259; k++) begin
      dcm_locked = 1'b1;
      wait_state("loop_run", T_RUN, 40);
      dcm_locked = 1'b0;
      wait_state("loop_wait", T_WAIT, 20);
    end
    chk("loss_saturated", 32'(lock_loss_count), 32'd255);

    // Lock glitch during SETTLE
    dcm_locked = 1'b1;
    wait_state("glitch_settle", T_SETTL, 10);
    tick(10);
    dcm_locked = 1'b0;
    tick(3);
    chk_state("glitch_back_wait", T_WAIT);
    chk("glitch_retry", 32'(retry_count), 32'd0);
    chk("glitch_core_rst", 32'(core_rst), 32'd1);
    dcm_locked = 1'b1;
    tick(3);
    chk_state("glitch_resettle", T_SETTL);
    tick(15);
    chk_state("glitch_settle_last", T_SETTL);
    tick(1);
    chk_state("glitch_run", T_RUN);
    chk("glitch_core_rel", 32'(core_rst), 32'd0);

    // CLKFX stopped indication while locked in RUN
    dcm_status = 8'h04;
`ifdef DCM_CLKFX_WATCH_EN
    tick(3);
    chk_state("clkfx_pulse", T_PULSE);
    chk("clkfx_core_rst", 32'(core_rst), 32'd1);
    chk("clkfx_dcm_rst", 32'(dcm_rst), 32'd1);
    dcm_status = 8'h00;
    wait_state("clkfx_rerun", T_RUN, 40);
`else
    tick(5);
    chk_state("clkfx_ignored", T_RUN);
    chk("clkfx_core_rst", 32'(core_rst), 32'd0);
    chk("clkfx_dcm_rst", 32'(dcm_rst), 32'd0);
    dcm_status = 8'h00;
`endif

    // Retry exhaustion
    dcm_locked = 1'b0;
    tick(3);
    chk_state("rt_pulse0", T_PULSE);
    chk("rt_loss_sat", 32'(lock_loss_count), 32'd255);
    tick(4);
    chk_state("rt_wait1", T_WAIT);
    tick(99);
    chk_state("rt_wait1_last", T_WAIT);
    chk("rt_retry0", 32'(retry_count), 32'd0);
    tick(1);
    chk_state("rt_pulse1", T_PULSE);
    chk("rt_retry1", 32'(retry_count), 32'd1);
    chk("rt_dcm_rst1", 32'(dcm_rst), 32'd1);
    tick(3);
    chk("rt_dcm_rst1_last", 32'(dcm_rst), 32'd1);
    tick(1);
    chk("rt_dcm_rst1_end", 32'(dcm_rst), 32'd0);
    tick(100);
    chk_state("rt_pulse2", T_PULSE);
    chk("rt_retry2", 32'(retry_count), 32'd2);
    tick(104);
    chk_state("rt_fail", T_FAIL);
    chk("rt_fail_flag", 32'(fail), 32'd1);
    chk("rt_retry3", 32'(retry_count), 32'd3);
    chk("rt_fail_dcm_rst", 32'(dcm_rst), 32'd1);
    chk("rt_fail_core_rst", 32'(core_rst), 32'd1);
    tick(5);
    chk_state("rt_fail_hold", T_FAIL);

    // Restart from FAIL, then a restart during PULSE must be ignored
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    chk_state("rs_pulse", T_PULSE);
    chk("rs_fail_clr", 32'(fail), 32'd0);
    chk("rs_retry_clr", 32'(retry_count), 32'd0);
    chk("rs_loss_kept", 32'(lock_loss_count), 32'd255);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    tick(2);
    chk_state("rs_ign_pulse", T_PULSE);
    tick(1);
    chk_state("rs_ign_wait", T_WAIT);

    // Async reset in the middle of WAIT_LOCK
    tick(50);
    chk("ar_pre_dcm_rst", 32'(dcm_rst), 32'd0);
    reset_n = 1'b0;
    #1;
    chk_state("ar_state", T_RESET);
    chk("ar_dcm_rst", 32'(dcm_rst), 32'd1);
    chk("ar_core_rst", 32'(core_rst), 32'd1);
    chk("ar_retry", 32'(retry_count), 32'd0);
    chk("ar_loss", 32'(lock_loss_count), 32'd0);
    chk("ar_fail", 32'(fail), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk_state("ar_restart", T_PULSE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
